fetch_ctrl: RTL and testbench

Fetch sequencer for the RISC-V core. Owns the architectural program counter, issues one instruction-memory request at a time over a valid/ready handshake, and delivers each fetched instruction with its PC to decode over a second valid/ready handshake. It sits between the PC datapath (+4 increment and target adder) and the instruction memory. Redirects from execute (branch, jump, trap return) are applied cleanly even while a fetch is in flight.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_next_pc.sv | 29 ++
 rtl/fetch_ctrl.sv | 131 +++++++++++++
 tb/tb_fetch_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } fetch_state_t;

   localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] FETCH_TRAP_VEC = 32'h0000_0100;
   localparam logic [31:0] INST_BYTES     = 32'd4;

   // Instructions are word aligned; any low address bit set is a fault.
   function automatic logic is_misaligned(input logic [31:0] addr);
      return addr[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC selector: redirect target (or trap vector), sequential +4 after a
// consumed instruction, or hold.
module fetch_next_pc
   import fetch_pkg::*;
#(
   parameter logic [31:0] TRAP_VEC = FETCH_TRAP_VEC
) (
   input  logic [31:0] pc,
   input  logic        redirect,
   input  logic [31:0] redir_pc,
   input  logic        advance,
   input  logic [31:0] inst_pc,
   output logic [31:0] next_pc,
   output logic        misalign
);

   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      next_pc  = pc;
      misalign = redirect && is_misaligned(redir_pc);
      // A redirect outranks the sequential step, even when decode consumes in the same cycle.
      if (redirect) begin
         next_pc = misalign ? TRAP_VEC : redir_pc;
      end else if (advance) begin
         next_pc = inst_pc + INST_BYTES;
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: one outstanding imem request, instruction hand-off to decode,
// redirect/flush handling. Optional counters under FETCH_CTRL_PERF_EN.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
   parameter logic [31:0] TRAP_VEC = FETCH_TRAP_VEC
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc,
   input  logic        redir_valid,
   input  logic [31:0] redir_pc,
   output logic        trap_misalign,
   output logic [31:0] trap_tval
`ifdef FETCH_CTRL_PERF_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_dropped
`endif
);

   fetch_state_t state;
   logic [31:0]  pc;
   logic         drop;
   logic [31:0]  next_pc;
   logic         misalign;
   logic         advance;

   assign advance = (state == HOLD) && inst_ready;

   fetch_next_pc #(.TRAP_VEC(TRAP_VEC)) u_next_pc (
      .pc       (pc),
      .redirect (redir_valid),
      .redir_pc (redir_pc),
      .advance  (advance),
      .inst_pc  (inst_pc),
      .next_pc  (next_pc),
      .misalign (misalign)
   );

   // NOTE: reset is synchronous, so it sits inside the clocked branch, not the sensitivity list.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= IDLE;
         pc             <= RESET_PC;
         drop           <= 1'b0;
         imem_req_valid <= 1'b0;
         imem_req_addr  <= RESET_PC;
         inst_valid     <= 1'b0;
         inst_data      <= '0;
         inst_pc        <= '0;
         trap_misalign  <= 1'b0;
         trap_tval      <= '0;
      end else begin
         pc            <= next_pc;
         trap_misalign <= misalign;
         if (misalign) trap_tval <= redir_pc;

         // Every entry into REQ loads the request address from next_pc.
         unique case (state)
            IDLE: begin
               state          <= REQ;
               imem_req_valid <= 1'b1;
               imem_req_addr  <= next_pc;
            end
            REQ: begin
               // The address is frozen until accepted; a redirect only marks the reply stale.
               if (redir_valid) drop <= 1'b1;
               if (imem_req_ready) begin
                  state          <= WAIT;
                  imem_req_valid <= 1'b0;
               end
            end
            WAIT: begin
               if (imem_rsp_valid) begin
                  if (drop || redir_valid) begin
                     drop           <= 1'b0;
                     state          <= REQ;
                     imem_req_valid <= 1'b1;
                     imem_req_addr  <= next_pc;
                  end else begin
                     state      <= HOLD;
                     inst_valid <= 1'b1;
                     inst_data  <= imem_rsp_data;
                     inst_pc    <= imem_req_addr;
                  end
               end else if (redir_valid) begin
                  drop <= 1'b1;
               end
            end
            HOLD: begin
               if (inst_ready || redir_valid) begin
                  state          <= REQ;
                  inst_valid     <= 1'b0;
                  imem_req_valid <= 1'b1;
                  imem_req_addr  <= next_pc;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef FETCH_CTRL_PERF_EN
   logic rsp_discard;
   logic hold_flush;

   assign rsp_discard = (state == WAIT) && imem_rsp_valid && (drop || redir_valid);
   assign hold_flush  = (state == HOLD) && redir_valid && !inst_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_fetched <= '0;
         perf_dropped <= '0;
      end else begin
         if (inst_valid && inst_ready)    perf_fetched <= perf_fetched + 32'd1;
         if (rsp_discard || hold_flush)   perf_dropped <= perf_dropped + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios, then randomized
// traffic checked against an instruction-stream reference model.
module tb_fetch_ctrl;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] TVEC   = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req_ready = 1'b0;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        inst_ready = 1'b0;
   logic        redir_valid = 1'b0;
   logic [31:0] redir_pc = '0;

   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        inst_valid;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        trap_misalign;
   logic [31:0] trap_tval;
`ifdef FETCH_CTRL_PERF_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_dropped;
`endif

   always #5 clk = ~clk;

   fetch_ctrl dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc),
      .redir_valid    (redir_valid),
      .redir_pc       (redir_pc),
      .trap_misalign  (trap_misalign),
      .trap_tval      (trap_tval)
`ifdef FETCH_CTRL_PERF_EN
      ,
      .perf_fetched   (perf_fetched),
      .perf_dropped   (perf_dropped)
`endif
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // Stream model: the address of the next instruction decode must receive.
   logic [31:0] exp_pc = RST_PC;
   logic [31:0] model_tval = '0;
   int          n_fetched = 0;

   // Memory responder state.
   bit          mem_pend = 1'b0;
   logic [31:0] mem_addr = '0;
   int          mem_dly = 0;
   int          mem_lat = 0;
   bit          rand_lat = 1'b0;

   bit          prev_stall = 1'b0;
   logic [31:0] stall_addr = '0;
   bit          prev_valid = 1'b0;
   bit          req_fired = 1'b0;
   logic [31:0] last_req_addr = '0;
   int          req_start[$];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs, predict edge events, advance, check traps.
   task automatic step(input logic rdy, input logic irdy, input logic rv,
                       input logic [31:0] rpc, input logic rstv = 1'b1);
      logic mis;
      rst_n          = rstv;
      imem_req_ready = rdy;
      inst_ready     = irdy;
      redir_valid    = rv;
      redir_pc       = rpc;
      imem_rsp_valid = 1'b0;
      if (mem_pend) begin
         if (mem_dly == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mem_addr);
            mem_pend       = 1'b0;
         end else begin
            mem_dly--;
         end
      end
      req_fired = 1'b0;
      mis = 1'b0;
      if (rstv) begin
         if (prev_stall) begin
            check("req_hold_valid", {31'b0, imem_req_valid}, 32'd1);
            check("req_hold_addr", imem_req_addr, stall_addr);
         end
         if (imem_req_valid && !prev_valid) req_start.push_back(cyc);
         if (inst_valid && irdy) begin
            check("inst_pc", inst_pc, exp_pc);
            check("inst_data", inst_data, mem_word(exp_pc));
            exp_pc += 32'd4;
            n_fetched++;
         end
         if (rv) begin
            mis    = (rpc[1:0] != 2'b00);
            exp_pc = mis ? TVEC : rpc;
         end
         if (imem_req_valid && rdy) begin
            check("one_outstanding", {31'b0, mem_pend}, 32'd0);
            mem_pend      = 1'b1;
            mem_addr      = imem_req_addr;
            mem_dly       = rand_lat ? int'($urandom_range(3, 0)) : mem_lat;
            req_fired     = 1'b1;
            last_req_addr = imem_req_addr;
         end
         prev_stall = imem_req_valid && !rdy;
         stall_addr = imem_req_addr;
         prev_valid = imem_req_valid;
      end else begin
         exp_pc     = RST_PC;
         n_fetched  = 0;
         prev_stall = 1'b0;
         prev_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (!rstv) model_tval = '0;
      else if (mis) model_tval = rpc;
      check("trap_misalign", {31'b0, trap_misalign}, {31'b0, mis});
      check("trap_tval", trap_tval, model_tval);
   endtask

   task automatic run_until_fire(input logic irdy, input int budget, input string tag);
      int k = 0;
      do begin
         step(1'b1, irdy, 1'b0, 32'h0);
         k++;
      end while (!req_fired && k < budget);
      check({tag, "_fire_timeout"}, {31'b0, req_fired}, 32'd1);
   endtask

   task automatic run_until_inst(input logic rdy, input int budget, input string tag);
      int k = 0;
      while (!inst_valid && k < budget) begin
         step(rdy, 1'b0, 1'b0, 32'h0);
         k++;
      end
      check({tag, "_inst_timeout"}, {31'b0, inst_valid}, 32'd1);
   endtask

   initial begin
      int k;
      logic [31:0] tgt;
      logic        rv;

      // Reset values
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
      check("rst_req_addr", imem_req_addr, RST_PC);
      check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
      check("rst_inst_data", inst_data, 32'h0);
      check("rst_inst_pc", inst_pc, 32'h0);
`ifdef FETCH_CTRL_PERF_EN
      check("rst_perf_fetched", perf_fetched, 32'h0);
      check("rst_perf_dropped", perf_dropped, 32'h0);
`endif

      // Release: one IDLE cycle, then the first request at RESET_PC
      req_start.delete();
      step(1'b1, 1'b1, 1'b0, 32'h0);
      check("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
      check("first_req_addr", imem_req_addr, RST_PC);
      run_until_fire(1'b1, 10, "seq0");
      check("seq0_addr", last_req_addr, 32'h0);
      run_until_fire(1'b1, 10, "seq1");
      check("seq1_addr", last_req_addr, 32'h4);

      // Memory not ready for 5 cycles at 0x8
      k = 0;
      while (!imem_req_valid && k < 10) begin
         step(1'b0, 1'b1, 1'b0, 32'h0);
         k++;
      end
      repeat (5) begin
         step(1'b0, 1'b1, 1'b0, 32'h0);
         check("stall_valid", {31'b0, imem_req_valid}, 32'd1);
         check("stall_addr", imem_req_addr, 32'h8);
      end
      check("req_start_count", 32'(req_start.size()), 32'd3);
      if (req_start.size() >= 3) begin
         check("req_gap_01", 32'(req_start[1] - req_start[0]), 32'd3);
         check("req_gap_12", 32'(req_start[2] - req_start[1]), 32'd3);
      end
      step(1'b1, 1'b1, 1'b0, 32'h0);
      check("stall_then_wait", {31'b0, imem_req_valid}, 32'd0);
      step(1'b0, 1'b1, 1'b0, 32'h0);
      check("stall_inst_valid", {31'b0, inst_valid}, 32'd1);
      check("stall_inst_pc", inst_pc, 32'h8);
      step(1'b0, 1'b1, 1'b0, 32'h0);

      // Redirect to 0x200 while waiting on the 0xC response
      mem_lat = 2;
      run_until_fire(1'b1, 10, "pre_redir");
      check("pre_redir_addr", last_req_addr, 32'hC);
      step(1'b0, 1'b1, 1'b1, 32'h200);
      k = 0;
      do begin
         step(1'b1, 1'b1, 1'b0, 32'h0);
         check("drop_no_inst", {31'b0, inst_valid}, 32'd0);
         k++;
      end while (!req_fired && k < 10);
      check("redir_fire", {31'b0, req_fired}, 32'd1);
      check("redir_addr", last_req_addr, 32'h200);
`ifdef FETCH_CTRL_PERF_EN
      check("perf_dropped_1", perf_dropped, 32'd1);
`endif

      // Misaligned redirect to 0x302 while holding the 0x200 instruction
      mem_lat = 0;
      run_until_inst(1'b0, 10, "hold200");
      check("hold200_pc", inst_pc, 32'h200);
      step(1'b0, 1'b0, 1'b1, 32'h302);
      check("mis_pulse", {31'b0, trap_misalign}, 32'd1);
      check("mis_tval", trap_tval, 32'h302);
      check("mis_flush", {31'b0, inst_valid}, 32'd0);
      check("mis_req_valid", {31'b0, imem_req_valid}, 32'd1);
      check("mis_req_addr", imem_req_addr, TVEC);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      check("mis_pulse_end", {31'b0, trap_misalign}, 32'd0);
      run_until_fire(1'b0, 10, "trapvec");
      check("trapvec_addr", last_req_addr, TVEC);
`ifdef FETCH_CTRL_PERF_EN
      check("perf_dropped_2", perf_dropped, 32'd2);
`endif

      // Redirect to the top word while decode consumes the held one
      run_until_inst(1'b0, 10, "hold100");
      step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
      check("top_req_addr", imem_req_addr, 32'hFFFF_FFFC);
      run_until_fire(1'b1, 10, "top");
      check("top_addr", last_req_addr, 32'hFFFF_FFFC);
      mem_lat = 3;
      run_until_fire(1'b1, 10, "wrap");
      check("wrap_addr", last_req_addr, 32'h0);

      // Reset while waiting; the late response must be ignored
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      repeat (4) begin
         step(1'b0, 1'b1, 1'b0, 32'h0);
         check("late_rsp_no_inst", {31'b0, inst_valid}, 32'd0);
      end
      check("late_rsp_consumed", {31'b0, mem_pend}, 32'd0);
      check("restart_req_valid", {31'b0, imem_req_valid}, 32'd1);
      check("restart_req_addr", imem_req_addr, RST_PC);
      mem_lat = 0;
      run_until_fire(1'b1, 10, "restart");
      check("restart_addr", last_req_addr, RST_PC);

      // Randomized traffic against the stream model
      rand_lat = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         rv  = ($urandom_range(99, 0) < 3);
         tgt = $urandom;
         case ($urandom_range(3, 0))
            0:       tgt[1:0] = 2'($urandom_range(3, 1));
            1:       tgt = 32'hFFFF_FFF0 | (tgt & 32'hC);
            default: tgt[1:0] = 2'b00;
         endcase
         step(($urandom_range(9, 0) < 7), ($urandom_range(9, 0) < 6), rv, tgt);
      end
`ifdef FETCH_CTRL_PERF_EN
      check("perf_fetched_total", perf_fetched, 32'(n_fetched));
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
